// File: rtl/hyper_trans_splitter.sv
// rtl/hyper_trans_splitter.sv - splits linear word requests into HyperBus PHY chunks at chip and burst limits
// Optional: define HYPER_SPLIT_RANGE_CHECK_EN to drop requests that run past the last chip and pulse err_o.
module hyper_trans_splitter #(
   parameter int AddrWidth    = 32,
   parameter int LenWidth     = 16,
   parameter int NumChips     = 2,
   parameter int ChipSizeLog2 = 23
) (
   input  logic                 clk_i,
   input  logic                 rst_n,
   input  logic [LenWidth-1:0]  max_burst_i,
   input  logic                 trans_valid_i,
   output logic                 trans_ready_o,
   input  logic [AddrWidth-1:0] trans_addr_i,
   input  logic [LenWidth-1:0]  trans_len_i,
   input  logic                 trans_write_i,
   output logic                 phy_valid_o,
   input  logic                 phy_ready_i,
   output logic [NumChips-1:0]  phy_cs_o,
   output logic [47:0]          phy_ca_o,
   output logic [LenWidth-1:0]  phy_len_o,
   output logic                 phy_last_o,
   output logic                 err_o
);

   localparam int WordBits = ChipSizeLog2 - 1;
   localparam int WAddrW   = AddrWidth - 1;
   localparam int RemW     = LenWidth + 1;
   localparam int CmpW     = (RemW > WordBits + 1) ? RemW : WordBits + 1;
   localparam int IdxW     = (NumChips > 1) ? $clog2(NumChips) : 1;
   localparam int HiW      = WAddrW - WordBits;

   typedef enum logic {IDLE, EMIT} state_e;

   state_e              state_q, state_d;
   logic [WAddrW-1:0]   cur_word_q, cur_word_d;
   logic [RemW-1:0]     rem_q, rem_d;
   logic                write_q, write_d;
   logic [LenWidth-1:0] max_q, max_d;
   logic                err_q, err_d;

   logic [WordBits-1:0] w;
   logic [HiW-1:0]      chip_hi;
   logic [CmpW-1:0]     to_end, n_cmp;
   logic [RemW-1:0]     n;
   logic [IdxW-1:0]     idx;
   logic [NumChips-1:0] cs;
   logic [47:0]         ca;
   logic                emit;
   logic                unused_ok;

   assign w         = cur_word_q[WordBits-1:0];
   assign chip_hi   = cur_word_q[WAddrW-1:WordBits];
   assign emit      = (state_q == EMIT);
   assign unused_ok = ^{trans_addr_i[0], chip_hi};

   // Chunk size: smallest of remaining words, words left in this chip and the latched burst cap.
   always_comb begin
      to_end = (CmpW'(1) << WordBits) - CmpW'(w);
      n_cmp  = CmpW'(rem_q);
      if (to_end < n_cmp) n_cmp = to_end;
      if ((max_q != '0) && (CmpW'(max_q) < n_cmp)) n_cmp = CmpW'(max_q);
      n = RemW'(n_cmp);
   end

   // Out-of-range chip indices fold onto the low index bits, then clamp to the last chip.
   always_comb begin
      idx = chip_hi[IdxW-1:0];
      if (int'(idx) >= NumChips) idx = IdxW'(NumChips - 1);
      for (int i = 0; i < NumChips; i++) cs[i] = (int'(idx) == i);
   end

   assign ca = {~write_q, 1'b0, 1'b1, 29'(w >> 3), 13'd0, w[2:0]};

   assign trans_ready_o = (state_q == IDLE) && !rst_n;
   assign phy_valid_o   = emit;
   assign phy_cs_o      = emit ? cs : '0;
   assign phy_ca_o      = emit ? ca : '0;
   assign phy_len_o     = emit ? LenWidth'(n - RemW'(1)) : '0;
   assign phy_last_o    = emit && (n == rem_q);
   assign err_o         = err_q;

   always_comb begin
      state_d    = state_q;
      cur_word_d = cur_word_q;
      rem_d      = rem_q;
      write_d    = write_q;
      max_d      = max_q;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (trans_valid_i && trans_ready_o) begin
               cur_word_d = trans_addr_i[AddrWidth-1:1];
               rem_d      = RemW'(trans_len_i) + RemW'(1);
               write_d    = trans_write_i;
               max_d      = max_burst_i;
               state_d    = EMIT;
`ifdef HYPER_SPLIT_RANGE_CHECK_EN
               begin
                  logic [AddrWidth-1:0] end_word;
                  end_word = {1'b0, trans_addr_i[AddrWidth-1:1]} + AddrWidth'(trans_len_i);
                  if ((end_word >> WordBits) >= AddrWidth'(NumChips)) begin
                     state_d = IDLE;
                     err_d   = 1'b1;
                  end
               end
`endif
            end
         end
         EMIT: begin
            if (phy_ready_i) begin
               cur_word_d = cur_word_q + WAddrW'(n);
               rem_d      = rem_q - n;
               if (n == rem_q) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_n) begin
      if (rst_n) begin
         state_q    <= IDLE;
         cur_word_q <= '0;
         rem_q      <= '0;
         write_q    <= 1'b0;
         max_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_word_q <= cur_word_d;
         rem_q      <= rem_d;
         write_q    <= write_d;
         max_q      <= max_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_hyper_trans_splitter.sv
// tb/tb_hyper_trans_splitter.sv - directed self-checking bench for hyper_trans_splitter
module tb_hyper_trans_splitter;

   logic        clk_i = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] max_burst_i = '0;
   logic        trans_valid_i = 1'b0;
   logic        trans_ready_o;
   logic [31:0] trans_addr_i = '0;
   logic [15:0] trans_len_i = '0;
   logic        trans_write_i = 1'b0;
   logic        phy_valid_o;
   logic        phy_ready_i = 1'b0;
   logic [1:0]  phy_cs_o;
   logic [47:0] phy_ca_o;
   logic [15:0] phy_len_o;
   logic        phy_last_o;
   logic        err_o;

   int n_checks = 0;
   int n_errors = 0;
   int waited;

   hyper_trans_splitter dut (
      .clk_i         (clk_i),
      .rst_n         (rst_n),
      .max_burst_i   (max_burst_i),
      .trans_valid_i (trans_valid_i),
      .trans_ready_o (trans_ready_o),
      .trans_addr_i  (trans_addr_i),
      .trans_len_i   (trans_len_i),
      .trans_write_i (trans_write_i),
      .phy_valid_o   (phy_valid_o),
      .phy_ready_i   (phy_ready_i),
      .phy_cs_o      (phy_cs_o),
      .phy_ca_o      (phy_ca_o),
      .phy_len_o     (phy_len_o),
      .phy_last_o    (phy_last_o),
      .err_o         (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge; returns just after the negedge following acceptance.
   task automatic send(input logic [31:0] addr, input logic [15:0] len,
                       input logic wr, input logic [15:0] mx);
      trans_addr_i  = addr;
      trans_len_i   = len;
      trans_write_i = wr;
      max_burst_i   = mx;
      trans_valid_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      trans_valid_i = 1'b0;
      max_burst_i   = 16'hFFFF;
   endtask

   task automatic take_chunk(input string tag, input logic [1:0] cs, input logic [47:0] ca,
                             input logic [15:0] len, input logic last, output int wcnt);
      wcnt = 0;
      while (!phy_valid_o && wcnt < 20) begin
         @(negedge clk_i);
         wcnt++;
      end
      chk({tag, ".valid"}, 64'(phy_valid_o), 64'd1);
      chk({tag, ".cs"},    64'(phy_cs_o),    64'(cs));
      chk({tag, ".ca"},    64'(phy_ca_o),    64'(ca));
      chk({tag, ".len"},   64'(phy_len_o),   64'(len));
      chk({tag, ".last"},  64'(phy_last_o),  64'(last));
      chk({tag, ".tready"}, 64'(trans_ready_o), 64'd0);
      phy_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      phy_ready_i = 1'b0;
   endtask

   initial begin
      @(negedge clk_i);
      chk("rst.tready", 64'(trans_ready_o), 64'd0);
      chk("rst.valid",  64'(phy_valid_o),   64'd0);
      chk("rst.ca",     64'(phy_ca_o),      64'd0);
      chk("rst.cs",     64'(phy_cs_o),      64'd0);
      chk("rst.err",    64'(err_o),         64'd0);
      rst_n = 1'b0;
      @(negedge clk_i);
      chk("idle.tready", 64'(trans_ready_o), 64'd1);

      // single chunk
      send(32'h0, 16'd7, 1'b1, 16'd0);
      take_chunk("t1", 2'b01, 48'h2000_0000_0000, 16'd7, 1'b1, waited);
      chk("t1.latency", 64'(waited), 64'd0);
      chk("t1.tready_after", 64'(trans_ready_o), 64'd1);
      chk("t1.valid_after",  64'(phy_valid_o),   64'd0);

      // burst split, no bubble between chunks
      send(32'h10, 16'd31, 1'b0, 16'd16);
      take_chunk("t2a", 2'b01, 48'hA000_0001_0000, 16'd15, 1'b0, waited);
      take_chunk("t2b", 2'b01, 48'hA000_0003_0000, 16'd15, 1'b1, waited);
      chk("t2.nobubble", 64'(waited), 64'd0);
      chk("t2.tready_after", 64'(trans_ready_o), 64'd1);

      // chip crossing
      send(32'h007F_FFF8, 16'd7, 1'b1, 16'd0);
      take_chunk("t3a", 2'b01, 48'h2007_FFFF_0004, 16'd3, 1'b0, waited);
      take_chunk("t3b", 2'b10, 48'h2000_0000_0000, 16'd3, 1'b1, waited);

      // backpressure holds chunk A stable
      send(32'h10, 16'd31, 1'b0, 16'd16);
      for (int i = 0; i < 5; i++) begin
         chk("t4.hold_valid", 64'(phy_valid_o), 64'd1);
         chk("t4.hold_ca",    64'(phy_ca_o),    64'hA000_0001_0000);
         chk("t4.hold_len",   64'(phy_len_o),   64'd15);
         chk("t4.hold_cs",    64'(phy_cs_o),    64'd1);
         chk("t4.hold_tready", 64'(trans_ready_o), 64'd0);
         @(negedge clk_i);
      end
      take_chunk("t4a", 2'b01, 48'hA000_0001_0000, 16'd15, 1'b0, waited);
      take_chunk("t4b", 2'b01, 48'hA000_0003_0000, 16'd15, 1'b1, waited);
      chk("t4.nobubble", 64'(waited), 64'd0);

      // reset mid-request
      send(32'h10, 16'd31, 1'b0, 16'd16);
      chk("t5.chunkA", 64'(phy_valid_o), 64'd1);
      rst_n = 1'b1;
      @(negedge clk_i);
      chk("t5.valid", 64'(phy_valid_o), 64'd0);
      chk("t5.ca",    64'(phy_ca_o),    64'd0);
      chk("t5.len",   64'(phy_len_o),   64'd0);
      chk("t5.cs",    64'(phy_cs_o),    64'd0);
      chk("t5.last",  64'(phy_last_o),  64'd0);
      chk("t5.tready_in_rst", 64'(trans_ready_o), 64'd0);
      rst_n = 1'b0;
      phy_ready_i = 1'b1;
      @(negedge clk_i);
      chk("t5.tready", 64'(trans_ready_o), 64'd1);
      for (int i = 0; i < 4; i++) begin
         chk("t5.no_chunkB", 64'(phy_valid_o), 64'd0);
         @(negedge clk_i);
      end
      phy_ready_i = 1'b0;

`ifdef HYPER_SPLIT_RANGE_CHECK_EN
      send(32'h00FF_FFFC, 16'd3, 1'b1, 16'd0);
      chk("t6.err",    64'(err_o),         64'd1);
      chk("t6.valid",  64'(phy_valid_o),   64'd0);
      chk("t6.tready", 64'(trans_ready_o), 64'd1);
      @(negedge clk_i);
      chk("t6.err_pulse", 64'(err_o),       64'd0);
      chk("t6.valid2",    64'(phy_valid_o), 64'd0);
`else
      // past the last chip: index 2 folds onto chip 0
      send(32'h00FF_FFFC, 16'd3, 1'b1, 16'd0);
      chk("t6.err", 64'(err_o), 64'd0);
      take_chunk("t6a", 2'b10, 48'h2007_FFFF_0006, 16'd1, 1'b0, waited);
      take_chunk("t6b", 2'b01, 48'h2000_0000_0000, 16'd1, 1'b1, waited);
      chk("t6.tready", 64'(trans_ready_o), 64'd1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1);
   end

endmodule
